vga_frame_reader: RTL and testbench

- Read-side counterpart to the ARM processor's image writes.
- The processor writes the equalized image into data memory. This block reads it back through a dedicated second dmem read port and unpacks it into 24-bit grayscale pixels for the VGA driver.
- It sits between dmem and the VGA driver's next_x/next_y/pixel_color interface.
- It prefetches words into a small buffer so each pixel is served with a fixed one-cycle latency.

---
 rtl/vga_pkg.sv | 23 ++
 rtl/vga_frame_reader_word_fifo.sv | 73 +++++++
 rtl/vga_frame_reader.sv | 124 ++++++++++++
 tb/tb_vga_frame_reader.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_pkg
// Brief    : Shared VGA types and constants for the frame-reader path.
// Revision : 1.0 - initial release
// ============================================================================
package vga_pkg;

   localparam int H_ACTIVE = 640;
   localparam int V_ACTIVE = 480;

   typedef logic [23:0] pixel_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2
   } reader_state_t;

   localparam pixel_t COLOR_BLACK = 24'h00_0000;

endpackage
`default_nettype wire

// File: rtl/vga_frame_reader_word_fifo.sv
`default_nettype none
// ============================================================================
// Module   : word_fifo
// Brief    : Small synchronous show-ahead FIFO with flush.
// Revision : 1.0 - initial release
// ============================================================================
module word_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         flush,
   input  logic                         push,
   input  logic [WIDTH-1:0]             push_data,
   input  logic                         pop,
   output logic [WIDTH-1:0]             pop_data,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int c_aw = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int c_cw = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [c_aw-1:0]  r_wr_ptr;
   logic [c_aw-1:0]  r_rd_ptr;
   logic [c_cw-1:0]  r_count;
   logic             w_push;
   logic             w_pop;

   function automatic logic [c_aw-1:0] next_ptr(input logic [c_aw-1:0] p);
      return (p == c_aw'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign empty    = (r_count == '0);
   assign full     = (r_count == c_cw'(DEPTH));
   assign count    = r_count;
   assign pop_data = r_mem[r_rd_ptr];

   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign w_pop  = pop && !empty;
   assign w_push = push && (!full || w_pop);

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= next_ptr(r_wr_ptr);
         end
         if (w_pop) begin
            r_rd_ptr <= next_ptr(r_rd_ptr);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/vga_frame_reader.sv
`default_nettype none
// ============================================================================
// Module   : vga_frame_reader
// Brief    : Prefetches the grayscale frame from dmem and serves 24-bit pixels.
// Revision : 1.0 - initial release
// ============================================================================
module vga_frame_reader
   import vga_pkg::*;
#(
   parameter int          IMG_W      = 256,
   parameter int          IMG_H      = 256,
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0100,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        frame_start,
   input  logic [9:0]  next_x,
   input  logic [9:0]  next_y,
   input  logic        pix_req,
   output logic        mem_rd_en,
   output logic [31:0] mem_addr,
   input  logic [31:0] mem_rdata,
   output logic [23:0] pixel_color,
   output logic        underrun
);

   localparam int          c_total_words = IMG_W * IMG_H / 4;
   localparam int          c_cnt_w       = $clog2(c_total_words) + 1;
   localparam int          c_fcw         = $clog2(FIFO_DEPTH + 1);
   localparam logic [31:0] c_img_w       = 32'(IMG_W);
   localparam logic [31:0] c_img_h       = 32'(IMG_H);
   localparam logic [31:0] c_depth       = 32'(FIFO_DEPTH);
   localparam logic [c_cnt_w-1:0] c_total = c_cnt_w'(c_total_words);

   reader_state_t      r_state;
   logic [c_cnt_w-1:0] r_words;
   logic               r_inflight;
   logic [1:0]         r_lane;

   logic [31:0]        w_head;
   logic               w_full;
   logic               w_empty;
   logic [c_fcw-1:0]   w_count;
   logic               w_in_image;
   logic               w_serve;
   logic               w_pop;
   logic               w_push;
   logic [7:0]         w_byte;

   assign w_in_image = (32'(next_x) < c_img_w) && (32'(next_y) < c_img_h);

   // The read in flight is counted against the depth so a response always has room.
   assign mem_rd_en = (r_state == FETCH) && (r_words < c_total) && !w_full &&
                      ((32'(w_count) + 32'(r_inflight)) < c_depth);

   assign w_serve = pix_req && w_in_image && !w_empty && !frame_start;
   assign w_pop   = w_serve && (r_lane == 2'd3);
   assign w_push  = r_inflight && !frame_start;
   assign w_byte  = w_head[{r_lane, 3'b000} +: 8];

   word_fifo #(
      .WIDTH (32),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .flush     (frame_start),
      .push      (w_push),
      .push_data (mem_rdata),
      .pop       (w_pop),
      .pop_data  (w_head),
      .full      (w_full),
      .empty     (w_empty),
      .count     (w_count)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= IDLE;
         r_words     <= '0;
         r_inflight  <= 1'b0;
         r_lane      <= 2'd0;
         mem_addr    <= BASE_ADDR;
         pixel_color <= COLOR_BLACK;
         underrun    <= 1'b0;
      end else if (frame_start) begin
         // Clearing r_inflight drops whatever response is still on its way.
         r_state     <= FETCH;
         r_words     <= '0;
         r_inflight  <= 1'b0;
         r_lane      <= 2'd0;
         mem_addr    <= BASE_ADDR;
         pixel_color <= COLOR_BLACK;
      end else begin
         r_inflight <= mem_rd_en;
         if (mem_rd_en) begin
            mem_addr <= mem_addr + 32'd4;
            r_words  <= r_words + 1'b1;
         end

         if (pix_req) begin
            if (!w_in_image) begin
               pixel_color <= COLOR_BLACK;
            end else if (w_empty) begin
               pixel_color <= COLOR_BLACK;
               underrun    <= 1'b1;
            end else begin
               pixel_color <= {w_byte, w_byte, w_byte};
               r_lane      <= r_lane + 2'd1;
            end
         end

         case (r_state)
            IDLE:    r_state <= IDLE;
            FETCH:   if (r_words == c_total) r_state <= DRAIN;
            DRAIN:   if (w_empty && !r_inflight) r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_vga_frame_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_frame_reader
// Brief    : Directed self-checking bench for vga_frame_reader on an 8x2 image.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_frame_reader;

   logic        clk = 1'b0;
   logic        reset;
   logic        frame_start;
   logic [9:0]  next_x;
   logic [9:0]  next_y;
   logic        pix_req;
   logic        mem_rd_en;
   logic [31:0] mem_addr;
   logic [31:0] mem_rdata;
   logic [23:0] pixel_color;
   logic        underrun;

   int          n_vec  = 0;
   int          n_miss = 0;
   logic [31:0] rd_log [$];
   logic [23:0] row0 [8];
   logic [23:0] row1 [8];

   always #5 clk = ~clk;

   vga_frame_reader #(
      .IMG_W      (8),
      .IMG_H      (2),
      .BASE_ADDR  (32'h0000_0100),
      .FIFO_DEPTH (2)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .frame_start (frame_start),
      .next_x      (next_x),
      .next_y      (next_y),
      .pix_req     (pix_req),
      .mem_rd_en   (mem_rd_en),
      .mem_addr    (mem_addr),
      .mem_rdata   (mem_rdata),
      .pixel_color (pixel_color),
      .underrun    (underrun)
   );

   function automatic logic [31:0] dmem(input logic [31:0] a);
      case (a)
         32'h100: return 32'h4433_2211;
         32'h104: return 32'h8877_6655;
         32'h108: return 32'hCCBB_AA99;
         32'h10C: return 32'h10FF_EEDD;
         default: return 32'hDEAD_BEEF;
      endcase
   endfunction

   // dmem model: data valid the cycle after the strobe.
   always @(posedge clk) begin
      if (mem_rd_en && !reset) rd_log.push_back(mem_addr);
      mem_rdata <= dmem(mem_addr);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic serve(input int x, input int y, input logic [23:0] exp, input string tag);
      pix_req = 1'b1;
      next_x  = 10'(x);
      next_y  = 10'(y);
      tick();
      pix_req = 1'b0;
      check_val(tag, 32'(pixel_color), 32'(exp));
   endtask

   initial begin
      row0 = '{24'h111111, 24'h222222, 24'h333333, 24'h444444,
               24'h555555, 24'h666666, 24'h777777, 24'h888888};
      row1 = '{24'h999999, 24'hAAAAAA, 24'hBBBBBB, 24'hCCCCCC,
               24'hDDDDDD, 24'hEEEEEE, 24'hFFFFFF, 24'h101010};

      reset = 1'b1; frame_start = 1'b0; pix_req = 1'b0; next_x = '0; next_y = '0;
      repeat (3) tick();
      check_val("rst_pixel", 32'(pixel_color), 32'h0);
      check_val("rst_rd_en", 32'(mem_rd_en), 32'h0);
      check_val("rst_addr", mem_addr, 32'h100);
      check_val("rst_underrun", 32'(underrun), 32'h0);
      reset = 1'b0;
      tick();
      check_val("idle_no_read", 32'(mem_rd_en), 32'h0);

      // Frame 1: full frame with out-of-image requests interleaved.
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      check_val("f1_first_addr", mem_addr, 32'h100);
      check_val("f1_first_rd_en", 32'(mem_rd_en), 32'h1);
      repeat (3) tick();
      serve(0, 0, row0[0], "f1_px0");
      serve(300, 0, 24'h0, "f1_out_x");
      serve(1, 0, row0[1], "f1_px1_after_out");
      serve(0, 5, 24'h0, "f1_out_y");
      for (int x = 2; x < 8; x++) serve(x, 0, row0[x], $sformatf("f1_r0_px%0d", x));
      for (int x = 0; x < 8; x++) serve(x, 1, row1[x], $sformatf("f1_r1_px%0d", x));
      repeat (6) tick();
      check_val("f1_read_count", 32'(rd_log.size()), 32'd4);
      for (int i = 0; i < 4; i++)
         check_val($sformatf("f1_read_addr%0d", i),
                   (i < rd_log.size()) ? rd_log[i] : 32'hFFFF_FFFF, 32'h100 + 32'(4 * i));
      check_val("f1_no_more_reads", 32'(mem_rd_en), 32'h0);
      check_val("f1_no_underrun", 32'(underrun), 32'h0);

      // Frame 2: request right after frame_start underruns.
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      serve(0, 0, 24'h0, "f2_underrun_px");
      check_val("f2_underrun_set", 32'(underrun), 32'h1);
      tick();
      serve(0, 0, row0[0], "f2_px0_late");
      check_val("f2_underrun_sticky", 32'(underrun), 32'h1);

      // Frame 3: restart mid-frame in the cycle a read response arrives.
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      repeat (3) tick();
      for (int x = 0; x < 4; x++) serve(x, 0, row0[x], $sformatf("f3_px%0d", x));
      check_val("f3_refill_rd_en", 32'(mem_rd_en), 32'h1);
      check_val("f3_refill_addr", mem_addr, 32'h108);
      tick();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      check_val("f3_restart_addr", mem_addr, 32'h100);
      check_val("f3_restart_rd_en", 32'(mem_rd_en), 32'h1);
      repeat (3) tick();
      serve(0, 0, row0[0], "f3_restart_px0");
      serve(1, 0, row0[1], "f3_restart_px1");
      check_val("f3_underrun_sticky", 32'(underrun), 32'h1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
`default_nettype wire
